mig_rw_arbiter: RTL and testbench

//  Shares one MIG user command port (app_addr/app_cmd/app_en/app_rdy) between one write

---
 rtl/mig_rw_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mig_rw_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_rw_arbiter.sv
// Round-robin owner of the single MIG command port, shared by one write and one read
// controller. One queued request per side, start pulse on grant, watchdog-bounded hold.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// ST_IDLE     | no owner; grants once calibrated and a request is pending
// ST_WR_START | one-cycle start pulse to write controller, pending consumed
// ST_WR_BUSY  | write controller owns the port until done or watchdog
// ST_RD_START | one-cycle start pulse to read controller, pending consumed
// ST_RD_BUSY  | read controller owns the port until done or watchdog
module mig_rw_arbiter #(
    parameter int ADDR_W      = 28,
    parameter int LEN_W       = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic              ui_clk,
    input  logic              rst,
    input  logic              init_calib_complete,

    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [LEN_W-1:0]  wr_req_len,
    output logic              wr_busy,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic [LEN_W-1:0]  rd_req_len,
    output logic              rd_busy,

    output logic              wr_ctrl_req,
    output logic [ADDR_W-1:0] wr_ctrl_addr,
    output logic [LEN_W-1:0]  wr_ctrl_len,
    input  logic              wr_ctrl_done,
    input  logic [ADDR_W-1:0] wr_ctrl_app_addr,
    input  logic [2:0]        wr_ctrl_app_cmd,
    input  logic              wr_ctrl_app_en,
    output logic              wr_ctrl_app_rdy,

    output logic              rd_ctrl_req,
    output logic [ADDR_W-1:0] rd_ctrl_addr,
    output logic [LEN_W-1:0]  rd_ctrl_len,
    input  logic              rd_ctrl_done,
    input  logic [ADDR_W-1:0] rd_ctrl_app_addr,
    input  logic [2:0]        rd_ctrl_app_cmd,
    input  logic              rd_ctrl_app_en,
    output logic              rd_ctrl_app_rdy,

    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    input  logic              app_rdy,

    output logic              wr_grant,
    output logic              rd_grant,
    output logic              err_timeout
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR_START = 3'd1;
    localparam logic [2:0] ST_WR_BUSY  = 3'd2;
    localparam logic [2:0] ST_RD_START = 3'd3;
    localparam logic [2:0] ST_RD_BUSY  = 3'd4;

    localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    logic [2:0]        state, state_nxt;
    logic              wr_pend, rd_pend;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic [LEN_W-1:0]  wr_len_q, rd_len_q;
    logic              last_wr;
    logic [WD_W-1:0]   wd_cnt;
    logic              wd_expired;
    logic              in_busy;

    // Watchdog counts down the BUSY cycles left; zero means this is the last one.
    assign wd_expired = (wd_cnt == '0);
    assign in_busy    = (state == ST_WR_BUSY) || (state == ST_RD_BUSY);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (init_calib_complete) begin
                    if (wr_pend && (!rd_pend || !last_wr))
                        state_nxt = ST_WR_START;
                    else if (rd_pend)
                        state_nxt = ST_RD_START;
                end
            end
            ST_WR_START: state_nxt = ST_WR_BUSY;
            ST_WR_BUSY:  if (wr_ctrl_done || wd_expired) state_nxt = ST_IDLE;
            ST_RD_START: state_nxt = ST_RD_BUSY;
            ST_RD_BUSY:  if (rd_ctrl_done || wd_expired) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            wr_grant    <= 1'b0;
            rd_grant    <= 1'b0;
            wr_ctrl_req <= 1'b0;
            rd_ctrl_req <= 1'b0;
            last_wr     <= 1'b0;
            err_timeout <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            state       <= state_nxt;
            wr_grant    <= (state_nxt == ST_WR_START) || (state_nxt == ST_WR_BUSY);
            rd_grant    <= (state_nxt == ST_RD_START) || (state_nxt == ST_RD_BUSY);
            wr_ctrl_req <= (state_nxt == ST_WR_START);
            rd_ctrl_req <= (state_nxt == ST_RD_START);

            if (state == ST_WR_BUSY && state_nxt == ST_IDLE)
                last_wr <= 1'b1;
            else if (state == ST_RD_BUSY && state_nxt == ST_IDLE)
                last_wr <= 1'b0;

            // A done in the expiring cycle is a clean finish, not a timeout.
            if ((state == ST_WR_BUSY && !wr_ctrl_done && wd_expired) ||
                (state == ST_RD_BUSY && !rd_ctrl_done && wd_expired))
                err_timeout <= 1'b1;

            if (state == ST_WR_START || state == ST_RD_START)
                wd_cnt <= WD_LOAD;
            else if (in_busy && !wd_expired)
                wd_cnt <= wd_cnt - WD_ONE;
        end
    end

    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) begin
            wr_pend   <= 1'b0;
            wr_addr_q <= '0;
            wr_len_q  <= '0;
        end else if (state == ST_WR_START) begin
            wr_pend <= 1'b0;
        end else if (wr_req && (wr_req_len != '0) && !wr_pend) begin
            wr_pend   <= 1'b1;
            wr_addr_q <= wr_req_addr;
            wr_len_q  <= wr_req_len;
        end
    end

    always_ff @(posedge ui_clk or posedge rst) begin
        if (rst) begin
            rd_pend   <= 1'b0;
            rd_addr_q <= '0;
            rd_len_q  <= '0;
        end else if (state == ST_RD_START) begin
            rd_pend <= 1'b0;
        end else if (rd_req && (rd_req_len != '0) && !rd_pend) begin
            rd_pend   <= 1'b1;
            rd_addr_q <= rd_req_addr;
            rd_len_q  <= rd_req_len;
        end
    end

    assign wr_busy      = wr_pend | wr_grant;
    assign rd_busy      = rd_pend | rd_grant;
    assign wr_ctrl_addr = wr_addr_q;
    assign wr_ctrl_len  = wr_len_q;
    assign rd_ctrl_addr = rd_addr_q;
    assign rd_ctrl_len  = rd_len_q;

    always_comb begin
        app_addr        = '0;
        app_cmd         = '0;
        app_en          = 1'b0;
        wr_ctrl_app_rdy = 1'b0;
        rd_ctrl_app_rdy = 1'b0;
        if (wr_grant) begin
            app_addr        = wr_ctrl_app_addr;
            app_cmd         = wr_ctrl_app_cmd;
            app_en          = wr_ctrl_app_en;
            wr_ctrl_app_rdy = app_rdy;
        end else if (rd_grant) begin
            app_addr        = rd_ctrl_app_addr;
            app_cmd         = rd_ctrl_app_cmd;
            app_en          = rd_ctrl_app_en;
            rd_ctrl_app_rdy = app_rdy;
        end
    end

endmodule

// File: tb/tb_mig_rw_arbiter.sv
// Bench for mig_rw_arbiter: directed scenarios plus random traffic, all compared each
// cycle against a queue-based transaction model of the arbitration rules.
module tb_mig_rw_arbiter;

    localparam int AW = 28;
    localparam int LW = 16;
    localparam int TO = 16;

    logic          ui_clk, rst, init_calib_complete;
    logic          wr_req, rd_req, wr_busy, rd_busy;
    logic [AW-1:0] wr_req_addr, rd_req_addr;
    logic [LW-1:0] wr_req_len, rd_req_len;
    logic          wr_ctrl_req, rd_ctrl_req, wr_ctrl_done, rd_ctrl_done;
    logic [AW-1:0] wr_ctrl_addr, rd_ctrl_addr, wr_ctrl_app_addr, rd_ctrl_app_addr, app_addr;
    logic [LW-1:0] wr_ctrl_len, rd_ctrl_len;
    logic [2:0]    wr_ctrl_app_cmd, rd_ctrl_app_cmd, app_cmd;
    logic          wr_ctrl_app_en, rd_ctrl_app_en, app_en, app_rdy;
    logic          wr_ctrl_app_rdy, rd_ctrl_app_rdy;
    logic          wr_grant, rd_grant, err_timeout;

    mig_rw_arbiter #(.ADDR_W(AW), .LEN_W(LW), .TIMEOUT_CYC(TO)) dut (
        .ui_clk(ui_clk), .rst(rst), .init_calib_complete(init_calib_complete),
        .wr_req(wr_req), .wr_req_addr(wr_req_addr), .wr_req_len(wr_req_len), .wr_busy(wr_busy),
        .rd_req(rd_req), .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len), .rd_busy(rd_busy),
        .wr_ctrl_req(wr_ctrl_req), .wr_ctrl_addr(wr_ctrl_addr), .wr_ctrl_len(wr_ctrl_len),
        .wr_ctrl_done(wr_ctrl_done), .wr_ctrl_app_addr(wr_ctrl_app_addr),
        .wr_ctrl_app_cmd(wr_ctrl_app_cmd), .wr_ctrl_app_en(wr_ctrl_app_en),
        .wr_ctrl_app_rdy(wr_ctrl_app_rdy),
        .rd_ctrl_req(rd_ctrl_req), .rd_ctrl_addr(rd_ctrl_addr), .rd_ctrl_len(rd_ctrl_len),
        .rd_ctrl_done(rd_ctrl_done), .rd_ctrl_app_addr(rd_ctrl_app_addr),
        .rd_ctrl_app_cmd(rd_ctrl_app_cmd), .rd_ctrl_app_en(rd_ctrl_app_en),
        .rd_ctrl_app_rdy(rd_ctrl_app_rdy),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .wr_grant(wr_grant), .rd_grant(rd_grant), .err_timeout(err_timeout)
    );

    initial ui_clk = 1'b0;
    always #5 ui_clk = ~ui_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: one-deep request queue per side, owner 0=none 1=wr 2=rd.
    typedef struct packed { logic [AW-1:0] addr; logic [LW-1:0] len; } req_t;
    req_t m_wr_q[$];
    req_t m_rd_q[$];
    int   m_owner, m_busy_n, m_last;
    bit   m_start, m_err;

    task automatic model_reset();
        m_wr_q.delete();
        m_rd_q.delete();
        m_owner  = 0;
        m_start  = 0;
        m_busy_n = 0;
        m_last   = 2;
        m_err    = 0;
    endtask

    task automatic model_step();
        bit   acc_w, acc_r, done_in;
        req_t r;
        acc_w = wr_req && (wr_req_len != 0) && (m_wr_q.size() == 0);
        acc_r = rd_req && (rd_req_len != 0) && (m_rd_q.size() == 0);
        if (m_owner == 0) begin
            if (init_calib_complete) begin
                if (m_wr_q.size() != 0 && (m_rd_q.size() == 0 || m_last == 2)) begin
                    m_owner = 1; m_start = 1;
                end else if (m_rd_q.size() != 0) begin
                    m_owner = 2; m_start = 1;
                end
            end
        end else if (m_start) begin
            m_start  = 0;
            m_busy_n = 0;
            if (m_owner == 1) void'(m_wr_q.pop_front());
            else              void'(m_rd_q.pop_front());
        end else begin
            m_busy_n++;
            done_in = (m_owner == 1) ? wr_ctrl_done : rd_ctrl_done;
            if (done_in || m_busy_n >= TO) begin
                if (!done_in) m_err = 1;
                m_last  = m_owner;
                m_owner = 0;
            end
        end
        if (acc_w) begin r.addr = wr_req_addr; r.len = wr_req_len; m_wr_q.push_back(r); end
        if (acc_r) begin r.addr = rd_req_addr; r.len = rd_req_len; m_rd_q.push_back(r); end
    endtask

    task automatic compare_all();
        logic [AW-1:0] e_addr;
        logic [2:0]    e_cmd;
        logic          e_en, e_wrdy, e_rrdy;
        e_addr = '0; e_cmd = '0; e_en = 1'b0; e_wrdy = 1'b0; e_rrdy = 1'b0;
        if (m_owner == 1) begin
            e_addr = wr_ctrl_app_addr; e_cmd = wr_ctrl_app_cmd; e_en = wr_ctrl_app_en;
            e_wrdy = app_rdy;
        end else if (m_owner == 2) begin
            e_addr = rd_ctrl_app_addr; e_cmd = rd_ctrl_app_cmd; e_en = rd_ctrl_app_en;
            e_rrdy = app_rdy;
        end
        check_eq("wr_grant",    64'(wr_grant),    64'(m_owner == 1));
        check_eq("rd_grant",    64'(rd_grant),    64'(m_owner == 2));
        check_eq("wr_ctrl_req", 64'(wr_ctrl_req), 64'(m_owner == 1 && m_start));
        check_eq("rd_ctrl_req", 64'(rd_ctrl_req), 64'(m_owner == 2 && m_start));
        check_eq("wr_busy",     64'(wr_busy),     64'(m_owner == 1 || m_wr_q.size() != 0));
        check_eq("rd_busy",     64'(rd_busy),     64'(m_owner == 2 || m_rd_q.size() != 0));
        check_eq("err_timeout", 64'(err_timeout), 64'(m_err));
        check_eq("app_addr",    64'(app_addr),    64'(e_addr));
        check_eq("app_cmd",     64'(app_cmd),     64'(e_cmd));
        check_eq("app_en",      64'(app_en),      64'(e_en));
        check_eq("wr_app_rdy",  64'(wr_ctrl_app_rdy), 64'(e_wrdy));
        check_eq("rd_app_rdy",  64'(rd_ctrl_app_rdy), 64'(e_rrdy));
        if (m_owner == 1 && m_start && m_wr_q.size() != 0) begin
            check_eq("wr_ctrl_addr", 64'(wr_ctrl_addr), 64'(m_wr_q[0].addr));
            check_eq("wr_ctrl_len",  64'(wr_ctrl_len),  64'(m_wr_q[0].len));
        end
        if (m_owner == 2 && m_start && m_rd_q.size() != 0) begin
            check_eq("rd_ctrl_addr", 64'(rd_ctrl_addr), 64'(m_rd_q[0].addr));
            check_eq("rd_ctrl_len",  64'(rd_ctrl_len),  64'(m_rd_q[0].len));
        end
    endtask

    // One clock: model advances on the edge, DUT is compared on the falling edge,
    // then one-shot inputs drop back to idle.
    task automatic tick();
        @(posedge ui_clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge ui_clk);
        compare_all();
        wr_req = 1'b0; rd_req = 1'b0; wr_ctrl_done = 1'b0; rd_ctrl_done = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 model_reset();
        compare_all();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_start(input bit side_wr, input int budget, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = side_wr ? wr_ctrl_req : rd_ctrl_req;
        end
        check_eq(tag, 64'(seen), 64'(1));
    endtask

    task automatic req_wr(input logic [AW-1:0] a, input logic [LW-1:0] l);
        wr_req = 1'b1; wr_req_addr = a; wr_req_len = l;
    endtask

    task automatic req_rd(input logic [AW-1:0] a, input logic [LW-1:0] l);
        rd_req = 1'b1; rd_req_addr = a; rd_req_len = l;
    endtask

    initial begin
        int n, starts;
        rst = 1'b1; init_calib_complete = 1'b0; app_rdy = 1'b0;
        wr_req = 1'b0; wr_req_addr = '0; wr_req_len = '0;
        rd_req = 1'b0; rd_req_addr = '0; rd_req_len = '0;
        wr_ctrl_done = 1'b0; wr_ctrl_app_addr = '0; wr_ctrl_app_cmd = '0; wr_ctrl_app_en = 1'b0;
        rd_ctrl_done = 1'b0; rd_ctrl_app_addr = '0; rd_ctrl_app_cmd = '0; rd_ctrl_app_en = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;

        // Uncalibrated request waits, then starts once calibration completes.
        req_wr(28'h100, 16'd4);
        tick(); tick(); tick();
        check_eq("t1_busy_no_calib", 64'(wr_busy), 64'(1));
        check_eq("t1_no_start", 64'(wr_ctrl_req), 64'(0));
        init_calib_complete = 1'b1;
        wait_start(1'b1, 5, "t1_start_seen");
        check_eq("t1_addr", 64'(wr_ctrl_addr), 64'h100);
        check_eq("t1_len", 64'(wr_ctrl_len), 64'd4);
        check_eq("t1_grant", 64'(wr_grant), 64'(1));
        tick();
        check_eq("t1_pulse_one_cycle", 64'(wr_ctrl_req), 64'(0));
        wr_ctrl_done = 1'b1;
        tick(); tick();

        // Tie after reset goes to write, then read after one idle cycle, then write again.
        do_reset();
        req_wr(28'h11, 16'd2); req_rd(28'h22, 16'd3);
        tick();
        wait_start(1'b1, 4, "t2_wr_first");
        tick();
        wr_ctrl_done = 1'b1;
        tick();
        check_eq("t2_idle_gap", 64'(rd_grant), 64'(0));
        tick();
        check_eq("t2_rd_after_gap", 64'(rd_ctrl_req), 64'(1));
        tick();
        rd_ctrl_done = 1'b1;
        tick();
        req_wr(28'h33, 16'd1); req_rd(28'h44, 16'd1);
        tick();
        wait_start(1'b1, 4, "t2_wr_alternate");
        check_eq("t2_rd_waiting", 64'(rd_busy), 64'(1));
        tick();
        wr_ctrl_done = 1'b1;
        tick();
        wait_start(1'b0, 4, "t2_rd_second");
        tick();
        rd_ctrl_done = 1'b1;
        tick();

        // Command mux while the read side owns the port.
        req_rd(28'h40, 16'd2);
        tick();
        wait_start(1'b0, 4, "t3_rd_start");
        rd_ctrl_app_en = 1'b1; rd_ctrl_app_cmd = 3'b001; rd_ctrl_app_addr = 28'h200;
        wr_ctrl_app_en = 1'b1; wr_ctrl_app_cmd = 3'b000; wr_ctrl_app_addr = 28'h3ff;
        app_rdy = 1'b1;
        tick();
        check_eq("t3_app_cmd", 64'(app_cmd), 64'd1);
        check_eq("t3_app_addr", 64'(app_addr), 64'h200);
        check_eq("t3_app_en", 64'(app_en), 64'(1));
        check_eq("t3_wr_rdy_gated", 64'(wr_ctrl_app_rdy), 64'(0));
        check_eq("t3_rd_rdy", 64'(rd_ctrl_app_rdy), 64'(1));
        rd_ctrl_done = 1'b1;
        tick();
        rd_ctrl_app_en = 1'b0; wr_ctrl_app_en = 1'b0; app_rdy = 1'b0;
        tick();

        // Watchdog release after TO busy cycles; queued write then proceeds.
        do_reset();
        req_rd(28'h55, 16'd8);
        tick();
        wait_start(1'b0, 4, "t4_rd_start");
        req_wr(28'h66, 16'd3);
        n = 0;
        while (rd_grant && n < 40) begin
            tick();
            n++;
        end
        check_eq("t4_busy_cycles", 64'(n - 1), 64'(TO));
        check_eq("t4_err_set", 64'(err_timeout), 64'(1));
        wait_start(1'b1, 4, "t4_wr_after_timeout");
        tick();
        wr_ctrl_done = 1'b1;
        tick(); tick();
        check_eq("t4_err_sticky", 64'(err_timeout), 64'(1));

        // Request filtering: duplicate while pending, zero length, and re-request on done.
        do_reset();
        req_wr(28'h10, 16'd5);
        tick();
        req_wr(28'h20, 16'd6);
        tick();
        starts = wr_ctrl_req ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            if (wr_grant && !wr_ctrl_req) wr_ctrl_done = 1'b1;
            tick();
            if (wr_ctrl_req) starts++;
        end
        check_eq("t5_dup_ignored", 64'(starts), 64'(1));
        req_wr(28'h99, 16'd0);
        tick();
        check_eq("t5_len0_busy", 64'(wr_busy), 64'(0));
        tick();
        check_eq("t5_len0_busy_later", 64'(wr_busy), 64'(0));
        req_wr(28'h30, 16'd7);
        tick();
        wait_start(1'b1, 4, "t5_first");
        tick();
        wr_ctrl_done = 1'b1;
        req_wr(28'h40, 16'd9);
        tick();
        check_eq("t5_queued_busy", 64'(wr_busy), 64'(1));
        check_eq("t5_idle_gap", 64'(wr_grant), 64'(0));
        tick();
        check_eq("t5_restart", 64'(wr_ctrl_req), 64'(1));
        check_eq("t5_restart_addr", 64'(wr_ctrl_addr), 64'h40);
        tick();
        wr_ctrl_done = 1'b1;
        tick();

        // Asynchronous reset in the middle of a write transaction.
        req_wr(28'h77, 16'd2);
        tick();
        wait_start(1'b1, 4, "t6_start");
        wr_ctrl_app_en = 1'b1; app_rdy = 1'b1;
        req_rd(28'h88, 16'd4);
        tick();
        #2 rst = 1'b1;
        #1 model_reset();
        check_eq("t6_grant_now", 64'(wr_grant), 64'(0));
        check_eq("t6_app_en_now", 64'(app_en), 64'(0));
        check_eq("t6_wr_busy_now", 64'(wr_busy), 64'(0));
        check_eq("t6_rd_pend_lost", 64'(rd_busy), 64'(0));
        tick();
        rst = 1'b0;
        starts = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wr_ctrl_req || rd_ctrl_req) starts++;
        end
        check_eq("t6_no_start", 64'(starts), 64'(0));
        wr_ctrl_app_en = 1'b0; app_rdy = 1'b0;

        // Random traffic, including calibration drops, stray dones and async resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                init_calib_complete = ($urandom_range(0, 19) != 0);
                wr_req       = ($urandom_range(0, 3) == 0);
                wr_req_addr  = AW'($urandom);
                wr_req_len   = ($urandom_range(0, 4) == 0) ? '0 : LW'($urandom_range(1, 65535));
                rd_req       = ($urandom_range(0, 3) == 0);
                rd_req_addr  = AW'($urandom);
                rd_req_len   = ($urandom_range(0, 4) == 0) ? '0 : LW'($urandom_range(1, 65535));
                wr_ctrl_done = ($urandom_range(0, 9) == 0);
                rd_ctrl_done = ($urandom_range(0, 9) == 0);
                wr_ctrl_app_addr = AW'($urandom);
                rd_ctrl_app_addr = AW'($urandom);
                wr_ctrl_app_cmd  = 3'($urandom);
                rd_ctrl_app_cmd  = 3'($urandom);
                wr_ctrl_app_en   = 1'($urandom);
                rd_ctrl_app_en   = 1'($urandom);
                app_rdy          = 1'($urandom);
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
